// File: rtl/mem_ctrl.sv
// Memory access controller between the CPU datapath and a synchronous single-port RAM.
// Optional write read-back verification is enabled by defining MEM_VERIFY_EN.
module mem_ctrl #(
  parameter int data_width = 4,
  parameter int addr_width = 4,
  parameter int mem_depth  = addr_width * addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic                  ready,
  output logic [data_width-1:0] rdata,
  output logic                  rvalid,
  output logic                  done,
  output logic                  bad_addr,
  output logic                  vfy_err,
  output logic                  ram_rw,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_datain,
  input  logic [data_width-1:0] ram_dataout
);

`ifdef MEM_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    VFY_RD  = 3'd3,
    VFY_CMP = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;
`endif

  localparam logic [31:0] DEPTH_C = 32'(mem_depth);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    addr_ok_s;
  logic [data_width-1:0]   rdata_nxt_s;
  logic                    rvalid_nxt_s;
  logic                    done_nxt_s;
  logic                    bad_addr_nxt_s;
  logic                    vfy_err_nxt_s;
  logic                    ram_rw_nxt_s;
  logic [addr_width-1:0]   ram_addr_nxt_s;
  logic [data_width-1:0]   ram_datain_nxt_s;

  assign addr_ok_s = (32'(addr) < DEPTH_C);
  assign ready     = (state_r == IDLE);

  // Next-state and next-output decode; ram_rw doubles as the latched request direction.
  always_comb begin
    state_nxt_s      = state_r;
    rdata_nxt_s      = rdata;
    rvalid_nxt_s     = 1'b0;
    done_nxt_s       = 1'b0;
    bad_addr_nxt_s   = 1'b0;
`ifdef MEM_VERIFY_EN
    vfy_err_nxt_s    = vfy_err;
`else
    vfy_err_nxt_s    = 1'b0;
`endif
    ram_rw_nxt_s     = ram_rw;
    ram_addr_nxt_s   = ram_addr;
    ram_datain_nxt_s = ram_datain;

    case (state_r)
      IDLE: begin
        ram_rw_nxt_s = 1'b0;
        if (req && addr_ok_s) begin
          ram_rw_nxt_s     = we;
          ram_addr_nxt_s   = addr;
          ram_datain_nxt_s = wdata;
          state_nxt_s      = ACCESS;
        end else if (req) begin
          // Out-of-range request: reject without touching the RAM pins.
          bad_addr_nxt_s = 1'b1;
          state_nxt_s    = IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      ACCESS: begin
        ram_rw_nxt_s = 1'b0;
        if (ram_rw) begin
`ifdef MEM_VERIFY_EN
          state_nxt_s = VFY_RD;
`else
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
`endif
        end else begin
          state_nxt_s = CAPTURE;
        end
      end

      CAPTURE: begin
        ram_rw_nxt_s = 1'b0;
        rdata_nxt_s  = ram_dataout;
        rvalid_nxt_s = 1'b1;
        state_nxt_s  = IDLE;
      end

`ifdef MEM_VERIFY_EN
      VFY_RD: begin
        ram_rw_nxt_s = 1'b0;
        state_nxt_s  = VFY_CMP;
      end

      VFY_CMP: begin
        ram_rw_nxt_s = 1'b0;
        // ram_datain still holds the written word, so it is the reference.
        if (ram_dataout != ram_datain) begin
          vfy_err_nxt_s = 1'b1;
        end else begin
          vfy_err_nxt_s = vfy_err;
        end
        done_nxt_s  = 1'b1;
        state_nxt_s = IDLE;
      end
`endif

      default: begin
        ram_rw_nxt_s = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rdata      <= {data_width{1'b0}};
      rvalid     <= 1'b0;
      done       <= 1'b0;
      bad_addr   <= 1'b0;
      vfy_err    <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= {addr_width{1'b0}};
      ram_datain <= {data_width{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      rdata      <= rdata_nxt_s;
      rvalid     <= rvalid_nxt_s;
      done       <= done_nxt_s;
      bad_addr   <= bad_addr_nxt_s;
      vfy_err    <= vfy_err_nxt_s;
      ram_rw     <= ram_rw_nxt_s;
      ram_addr   <= ram_addr_nxt_s;
      ram_datain <= ram_datain_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table plus directed reset/burst/verify sequences,
// with a read-data scoreboard queue and a behavioural synchronous RAM.
module tb_mem_ctrl;
  localparam int DW = 4;
  localparam int AW = 5;
`ifdef MEM_VERIFY_EN
  localparam int   WR_LAT = 3;
  localparam logic VFY_ON = 1'b1;
`else
  localparam int   WR_LAT = 1;
  localparam logic VFY_ON = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_bad;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          done;
  logic          bad_addr;
  logic          vfy_err;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_datain;
  logic [DW-1:0] ram_dataout;

  logic [DW-1:0] mem [0:31];
  logic          force_rd;
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;

  mem_ctrl #(.data_width(DW), .addr_width(AW), .mem_depth(25)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .done(done), .bad_addr(bad_addr),
    .vfy_err(vfy_err), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_dataout(ram_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM; force_rd corrupts read-back for the verify test.
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_datain;
    ram_dataout <= force_rd ? 4'h4 : mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rvalid pops the oldest expected read word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rdata %0h expected no rvalid", rdata);
      end else begin
        chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
  end

  // Called at a negedge; holds req until accepted and returns at the negedge after E0.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic bad, input logic [DW-1:0] er, output logic ok);
    int n = 0;
    ok = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready %0b expected 1 within 50 cycles", ready);
    end else begin
      @(posedge clk);
      if (!w && !bad) exp_q.push_back(er);
      @(negedge clk);
      ok = 1'b1;
    end
  endtask

  task automatic issue_chk(input vec_t v);
    logic ok;
    send(v.we, v.addr, v.wdata, v.exp_bad, v.exp_rdata, ok);
    req = 1'b0;
    if (ok) begin
      if (v.exp_bad) begin
        chk("bad_pulse", 32'(bad_addr), 32'd1);
        chk("bad_ready", 32'(ready), 32'd1);
        chk("bad_rw", 32'(ram_rw), 32'd0);
        chk("bad_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("bad_clear", 32'(bad_addr), 32'd0);
        chk("bad_norvalid", 32'(rvalid), 32'd0);
      end else if (v.we) begin
        chk("wr_rw", 32'(ram_rw), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'(v.addr));
        chk("wr_data", 32'(ram_datain), 32'(v.wdata));
        chk("wr_busy", 32'(ready), 32'd0);
        for (int k = 1; k <= WR_LAT; k++) begin
          @(negedge clk);
          chk("wr_rw_low", 32'(ram_rw), 32'd0);
          chk("wr_done", 32'(done), (k == WR_LAT) ? 32'd1 : 32'd0);
        end
        chk("wr_ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk("wr_done_clear", 32'(done), 32'd0);
      end else begin
        chk("rd_rw", 32'(ram_rw), 32'd0);
        chk("rd_busy", 32'(ready), 32'd0);
        @(negedge clk);
        chk("rd_rvalid_early", 32'(rvalid), 32'd0);
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        chk("rd_ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t vecs [9];
    logic ok;
    int   d0;

    vecs[0] = '{1'b1, 5'd3,  4'hA, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 5'd3,  4'h0, 1'b0, 4'hA};
    vecs[2] = '{1'b1, 5'd24, 4'h7, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 5'd24, 4'h0, 1'b0, 4'h7};
    vecs[4] = '{1'b0, 5'd25, 4'h0, 1'b1, 4'h0};
    vecs[5] = '{1'b1, 5'd31, 4'h9, 1'b1, 4'h0};
    vecs[6] = '{1'b1, 5'd0,  4'hF, 1'b0, 4'h0};
    vecs[7] = '{1'b0, 5'd0,  4'h0, 1'b0, 4'hF};
    vecs[8] = '{1'b0, 5'd3,  4'h0, 1'b0, 4'hA};

    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    force_rd = 1'b0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bad", 32'(bad_addr), 32'd0);
    chk("rst_vfy", 32'(vfy_err), 32'd0);
    chk("rst_rw", 32'(ram_rw), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_datain", 32'(ram_datain), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) issue_chk(vecs[i]);
    chk("vfy_clean", 32'(vfy_err), 32'd0);

    // Back-to-back writes with req held high, then read everything back.
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i), 1'b0, 4'h0, ok);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("burst_done_cnt", 32'(done_cnt - d0), 32'd16);
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), 4'h0, 1'b0, DW'(i), ok);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("burst_drain", 32'(exp_q.size()), 32'd0);
    chk("burst_last_rdata", 32'(rdata), 32'hF);

    // Reset while the read sits in CAPTURE.
    req = 1'b1; we = 1'b0; addr = 5'd3;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("mid_busy", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", 32'(rdata), 32'd0);
    chk("mid_ready", 32'(ready), 32'd1);
    chk("mid_rw", 32'(ram_rw), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_late_rvalid", 32'(rvalid), 32'd0);

    // Write-verify: corrupted read-back, then a clean write must not clear the flag.
    force_rd = 1'b1;
    issue_chk('{1'b1, 5'd5, 4'h5, 1'b0, 4'h0});
    force_rd = 1'b0;
    chk("vfy_set", 32'(vfy_err), 32'(VFY_ON));
    issue_chk('{1'b1, 5'd6, 4'h6, 1'b0, 4'h0});
    chk("vfy_sticky", 32'(vfy_err), 32'(VFY_ON));
    issue_chk('{1'b0, 5'd5, 4'h0, 1'b0, 4'h5});
    chk("vfy_sticky_rd", 32'(vfy_err), 32'(VFY_ON));
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
